// File: rtl/reg_arb_pipe.sv
// reg_arb_pipe: registered N-to-1 register-bus arbiter, round-robin or fixed priority.
// Optional downstream watchdog is built when REG_ARB_PIPE_TIMEOUT_EN is defined.

package reg_arb_pipe_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module reg_arb_pipe
    import reg_arb_pipe_pkg::*;
#(
    parameter int unsigned NoPorts       = 2,
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t,
    parameter bit          FixedPrio     = 1'b0,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  req_t [NoPorts-1:0] in_req_i,
    output rsp_t [NoPorts-1:0] in_rsp_o,
    output req_t               out_req_o,
    input  rsp_t               out_rsp_i,
    output logic               busy_o
);

    localparam int unsigned IdxW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

    typedef logic [IdxW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e               state;
    state_e               state_next;
    idx_t                 ptr;
    idx_t                 next_ptr;
    idx_t                 gnt_q;
    idx_t                 win_idx;
    logic                 any_valid;
    logic [AW-1:0]        win_addr;
    logic                 win_write;
    logic [DW-1:0]        win_wdata;
    logic [DW/8-1:0]      win_wstrb;
    logic                 timeout;
    logic                 done;
    req_t                 req_reg;
    rsp_t [NoPorts-1:0]   rsp_reg;

    // Scan from the pointer upward with wrap; fixed priority always scans from index 0.
    always_comb begin
        int unsigned cand;
        idx_t        cand_idx;
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < NoPorts; off++) begin
            if (FixedPrio) begin
                cand = off;
            end else begin
                cand = 32'(ptr) + off;
                if (cand >= NoPorts) begin
                    cand = cand - NoPorts;
                end
            end
            cand_idx = idx_t'(cand);
            if (!any_valid && in_req_i[cand_idx].valid) begin
                any_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_addr  = in_req_i[win_idx].addr;
    assign win_write = in_req_i[win_idx].write;
    assign win_wdata = in_req_i[win_idx].wdata;
    assign win_wstrb = in_req_i[win_idx].wstrb;
    assign next_ptr  = ((32'(win_idx) + 32'd1) >= NoPorts) ? '0 : win_idx + idx_t'(1);

`ifdef REG_ARB_PIPE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] wait_cnt;

    // Held at zero outside ISSUE so every transaction starts its own count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state != ISSUE) begin
            wait_cnt <= '0;
        end else if (!out_rsp_i.ready) begin
            wait_cnt <= wait_cnt + CntW'(1);
        end
    end

    assign timeout = (state == ISSUE) && (wait_cnt == CntW'(TimeoutCycles - 1));
`else
    assign timeout = 1'b0;
`endif

    assign done = (state == ISSUE) && (out_rsp_i.ready || timeout);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = ISSUE;
            ISSUE:   if (done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Payload is left in place after valid drops; only valid carries meaning outside ISSUE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_reg <= '0;
            gnt_q   <= '0;
            ptr     <= '0;
        end else if (state == IDLE && any_valid) begin
            gnt_q         <= win_idx;
            req_reg.addr  <= win_addr;
            req_reg.write <= win_write;
            req_reg.wdata <= win_wdata;
            req_reg.wstrb <= win_wstrb;
            req_reg.valid <= 1'b1;
            if (!FixedPrio) begin
                ptr <= next_ptr;
            end
        end else if (done) begin
            req_reg.valid <= 1'b0;
        end
    end

    // A real downstream ready wins over a simultaneous watchdog expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_reg <= '0;
        end else begin
            rsp_reg <= '0;
            if (done) begin
                rsp_reg[gnt_q].ready <= 1'b1;
                rsp_reg[gnt_q].error <= out_rsp_i.ready ? out_rsp_i.error : 1'b1;
                rsp_reg[gnt_q].rdata <= out_rsp_i.ready ? out_rsp_i.rdata : '0;
            end
        end
    end

    assign out_req_o = req_reg;
    assign in_rsp_o  = rsp_reg;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_reg_arb_pipe.sv
// tb_reg_arb_pipe: self-checking bench for reg_arb_pipe, transaction-level model on a
// 4-port round-robin instance plus directed checks on a 4-port fixed-priority instance.
`timescale 1ns/1ps
module tb_reg_arb_pipe;
    import reg_arb_pipe_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef REG_ARB_PIPE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    reg_req_t [N-1:0]   req;
    reg_rsp_t [N-1:0]   rsp;
    reg_req_t           out_req;
    reg_rsp_t           slave;
    logic               busy;
    reg_req_t [N-1:0]   fp_req;
    reg_rsp_t [N-1:0]   fp_rsp;
    reg_req_t           fp_out_req;
    reg_rsp_t           fp_slave;
    logic               fp_busy;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int got[$];
    int when_c[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int fp_cnt2;
    int fp_cnt_other;
    reg_req_t w_exp;

    // Model state: one outstanding transaction, one response cycle, round-robin pointer.
    bit          m_active;
    bit          m_resp;
    bit          m_clean;
    int          m_ptr;
    int          m_gnt;
    int          m_wait;
    int          m_rsp_port;
    int          m_pick;
    reg_req_t    m_req;
    logic [31:0] m_rdata;
    logic        m_err;

    always #5 clk = ~clk;

    reg_arb_pipe #(
        .NoPorts(N), .AW(32), .DW(32), .req_t(reg_req_t), .rsp_t(reg_rsp_t),
        .FixedPrio(1'b0), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .in_req_i(req), .in_rsp_o(rsp),
        .out_req_o(out_req), .out_rsp_i(slave), .busy_o(busy)
    );

    reg_arb_pipe #(
        .NoPorts(N), .AW(32), .DW(32), .req_t(reg_req_t), .rsp_t(reg_rsp_t),
        .FixedPrio(1'b1), .TimeoutCycles(TO)
    ) dut_fp (
        .clk_i(clk), .rst_i(rst), .in_req_i(fp_req), .in_rsp_o(fp_rsp),
        .out_req_o(fp_out_req), .out_rsp_i(fp_slave), .busy_o(fp_busy)
    );

    function automatic void expectEq(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic finishTxn(input logic [31:0] rdata, input logic err);
        m_active    = 1'b0;
        m_resp      = 1'b1;
        m_rsp_port  = m_gnt;
        m_rdata     = rdata;
        m_err       = err;
        m_req.valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            m_resp     = 1'b0;
            m_clean    = 1'b1;
            m_ptr      = 0;
            m_gnt      = 0;
            m_wait     = 0;
            m_rsp_port = -1;
            m_req      = '0;
            m_rdata    = '0;
            m_err      = 1'b0;
        end else begin
            m_rsp_port = -1;
            if (m_resp) begin
                m_resp = 1'b0;
            end else if (m_active) begin
                if (slave.ready) begin
                    finishTxn(slave.rdata, slave.error);
                end else if (TO_EN && m_wait == TO - 1) begin
                    finishTxn(32'h0, 1'b1);
                end else begin
                    m_wait++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    m_pick = (m_ptr + k) % N;
                    if (!m_active && req[m_pick].valid) begin
                        m_active = 1'b1;
                        m_clean  = 1'b0;
                        m_gnt    = m_pick;
                        m_wait   = 0;
                        m_req    = req[m_pick];
                        m_ptr    = (m_pick + 1) % N;
                    end
                end
            end
        end
    end

    task automatic checkOutput();
        reg_rsp_t e;
        expectEq("busy", busy, m_active || m_resp);
        expectEq("out_valid", out_req.valid, m_active);
        if (m_active || m_clean) begin
            expectEq("out_req", out_req, m_req);
        end
        for (int i = 0; i < N; i++) begin
            e = '0;
            if (i == m_rsp_port) begin
                e.rdata = m_rdata;
                e.error = m_err;
                e.ready = 1'b1;
            end
            expectEq($sformatf("rsp_port%0d", i), rsp[i], e);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input int port, input bit valid, input logic [31:0] addr,
                                 input bit write, input logic [31:0] wdata, input logic [3:0] wstrb);
        req[port].valid = valid;
        req[port].addr  = addr;
        req[port].write = write;
        req[port].wdata = wdata;
        req[port].wstrb = wstrb;
    endtask

    task automatic setSlave(input bit ready, input logic [31:0] rdata, input bit error);
        slave.ready = ready;
        slave.rdata = rdata;
        slave.error = error;
    endtask

    initial begin
        req      = '0;
        fp_req   = '0;
        slave    = '0;
        fp_slave = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        expectEq("reset_busy", busy, 1'b0);
        expectEq("reset_out_req", out_req, '0);
        expectEq("reset_rsp", rsp, '0);
        check_en = 1'b1;
        rst      = 1'b0;

        $display("[TB] round-robin fairness");
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
        setSlave(1'b1, 32'hA5A50000, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rsp[i].ready) begin
                    got.push_back(i);
                    when_c.push_back(c);
                end
            end
        end
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        setSlave(1'b0, 32'h0, 1'b0);
        expectEq("rr_grant_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            expectEq($sformatf("rr_order%0d", k), got[k], exp_order[k]);
            expectEq($sformatf("rr_cycle%0d", k), when_c[k], 2 + 3 * k);
        end

        $display("[TB] single read");
        @(negedge clk);
        applyStimulus(1, 1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        expectEq("rd_valid_c1", out_req.valid, 1'b1);
        expectEq("rd_addr_c1", out_req.addr, 32'h40);
        @(negedge clk);
        @(negedge clk);
        expectEq("rd_valid_c3", out_req.valid, 1'b1);
        setSlave(1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        expectEq("rd_rsp1_ready", rsp[1].ready, 1'b1);
        expectEq("rd_rsp1_rdata", rsp[1].rdata, 32'hDEADBEEF);
        expectEq("rd_rsp0_ready", rsp[0].ready, 1'b0);
        expectEq("rd_rsp3_ready", rsp[3].ready, 1'b0);
        expectEq("rd_valid_c4", out_req.valid, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        setSlave(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        expectEq("rd_idle_busy", busy, 1'b0);

        $display("[TB] write with error");
        applyStimulus(0, 1'b1, 32'h08, 1'b1, 32'h12345678, 4'hF);
        @(negedge clk);
        w_exp       = '0;
        w_exp.addr  = 32'h08;
        w_exp.write = 1'b1;
        w_exp.wdata = 32'h12345678;
        w_exp.wstrb = 4'hF;
        w_exp.valid = 1'b1;
        expectEq("wr_payload", out_req, w_exp);
        setSlave(1'b1, 32'h0BAD0000, 1'b1);
        @(negedge clk);
        expectEq("wr_rsp0_ready", rsp[0].ready, 1'b1);
        expectEq("wr_rsp0_error", rsp[0].error, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        setSlave(1'b0, 32'h0, 1'b0);
        @(negedge clk);

        $display("[TB] reset during ISSUE");
        applyStimulus(2, 1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        expectEq("rst_pre_valid", out_req.valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        expectEq("rst_busy", busy, 1'b0);
        expectEq("rst_out_req", out_req, '0);
        expectEq("rst_rsp", rsp, '0);
        rst = 1'b0;
        applyStimulus(2, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 32'h204, 1'b0, 32'h0, 4'h0);
        applyStimulus(3, 1'b1, 32'h20C, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        expectEq("rst_first_grant_addr", out_req.addr, 32'h204);
        setSlave(1'b1, 32'h11110001, 1'b0);
        @(negedge clk);
        expectEq("rst_rsp1_ready", rsp[1].ready, 1'b1);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        expectEq("rst_port3_addr", out_req.addr, 32'h20C);
        @(negedge clk);
        expectEq("rst_rsp3_ready", rsp[3].ready, 1'b1);
        applyStimulus(3, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        setSlave(1'b0, 32'h0, 1'b0);
        @(negedge clk);

`ifdef REG_ARB_PIPE_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        applyStimulus(0, 1'b1, 32'h300, 1'b0, 32'h0, 4'h0);
        repeat (8) @(negedge clk);
        expectEq("to_valid_c8", out_req.valid, 1'b1);
        @(negedge clk);
        expectEq("to_rsp0_ready", rsp[0].ready, 1'b1);
        expectEq("to_rsp0_error", rsp[0].error, 1'b1);
        expectEq("to_rsp0_rdata", rsp[0].rdata, 32'h0);
        expectEq("to_valid_c9", out_req.valid, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        expectEq("to_idle_busy", busy, 1'b0);
`endif

        $display("[TB] fixed priority");
        fp_req[2].valid = 1'b1;
        fp_req[2].addr  = 32'h520;
        fp_req[3].valid = 1'b1;
        fp_req[3].addr  = 32'h530;
        fp_slave.ready  = 1'b1;
        fp_slave.rdata  = 32'hCAFE0002;
        fp_cnt2         = 0;
        fp_cnt_other    = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (fp_out_req.valid) expectEq("fp_out_addr", fp_out_req.addr, 32'h520);
            if (fp_rsp[2].ready) fp_cnt2++;
            if (fp_rsp[0].ready || fp_rsp[1].ready || fp_rsp[3].ready) fp_cnt_other++;
        end
        fp_req   = '0;
        fp_slave = '0;
        expectEq("fp_port2_served", fp_cnt2, 4);
        expectEq("fp_others_served", fp_cnt_other, 0);

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
